fadd_wb_queue: RTL

FADD_WB_QUEUE -- requirements
Module: fadd_wb_queue

---
 rtl/fadd_wb_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/fadd_wb_queue.sv
// Writeback queue for a 3-stage pipelined FP adder: tracks destinations of
// in-flight ops, buffers normalized results in a FIFO, stalls the adder when
// the FIFO cannot accept, and flags RAW hazards for the decode stage.
module fadd_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clock,
    input  logic          clrn,
    input  logic          issue,
    input  logic [4:0]    wn,
    input  logic [31:0]   s,
    input  logic [4:0]    fs,
    input  logic [4:0]    ft,
    input  logic          wb_ready,
    output logic          e,
    output logic          wb_valid,
    output logic [4:0]    wb_wn,
    output logic [31:0]   wb_data,
    output logic [AW:0]   count,
    output logic          fhaz
);

    logic          r_v1;
    logic          r_v2;
    logic [4:0]    r_t1;
    logic [4:0]    r_t2;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic [4:0]    r_q_wn   [DEPTH];
    logic [31:0]   r_q_data [DEPTH];

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_hit;
    logic [AW-1:0] w_off;

    // Stall only when stage 2 must push into a full FIFO that is not draining.
    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign e        = ~(r_v2 & w_full & ~wb_ready);
    assign wb_valid = (r_count != '0);
    assign w_push   = r_v2 & e;
    assign w_pop    = wb_valid & wb_ready;
    assign count    = r_count;
    assign wb_wn    = wb_valid ? r_q_wn[r_head]   : '0;
    assign wb_data  = wb_valid ? r_q_data[r_head] : '0;
    assign fhaz     = w_hit;

    // Destination tags shadowing the adder's two pipeline registers.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_v1 <= 1'b0;
            r_t1 <= '0;
            r_v2 <= 1'b0;
            r_t2 <= '0;
        end else if (e) begin
            r_v1 <= issue;
            r_t1 <= wn;
            r_v2 <= r_v1;
            r_t2 <= r_t1;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_pop)  r_head <= r_head + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; stale entries are masked by count, so no reset needed.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_wn[r_tail]   <= r_t2;
            r_q_data[r_tail] <= s;
        end
    end

    // Hazard: decode sources against every pending destination, reg 0 included.
    always_comb begin
        w_hit = 1'b0;
        w_off = '0;
        if (r_v1 && (fs == r_t1 || ft == r_t1)) w_hit = 1'b1;
        if (r_v2 && (fs == r_t2 || ft == r_t2)) w_hit = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_off = AW'(i) - r_head;
            if (({1'b0, w_off} < r_count) && (r_q_wn[i] == fs || r_q_wn[i] == ft)) begin
                w_hit = 1'b1;
            end
        end
    end

endmodule
